tiny_nn_result_capture: RTL and testbench
=========================================

Name: tiny_nn_result_capture

Overview:
- Sits directly downstream of tiny_nn_top.
- Snoops the same 16-bit command/data stream that tiny_nn_top receives, and tracks its convolve sequencing in lock-step.
- Reassembles the high/low byte pairs that tiny_nn_top drives on its 8-bit output into 16-bit fp_t results.
- Buffers those results in a small FIFO and presents them over a valid/ready interface to the downstream consumer (host readback / next layer).

Parameters:
- CountWidth, 12, width of the convolve count field in the command word; must match tiny_nn_top.
- ValArraySize, 8, number of parameter-load cycles after a convolve command; must match tiny_nn_top (4x2 array).
- FifoDepth, 4, result FIFO entries; power of two, >=2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_data_i  in  16  same word driven into tiny_nn_top data_i
- nn_data_i  in  8  tiny_nn_top data_o
- res_o  out  16  fp_t result at FIFO head
- res_valid_o  out  1  FIFO non-empty
- res_ready_i  in  1  consumer accepts res_o when res_valid_o is high
- busy_o  out  1  capture sequence in progress
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full
- overflow_clr_i  in  1  clears overflow_o

Behaviour:
- Reset (async, rst_ni low):
  - State is CapIdle; FIFO is empty.
  - res_valid_o=0, busy_o=0, overflow_o=0, res_o=0.
  - Phase, counters and the held high byte all reset to 0.
- State machine (registered, mirrors tiny_nn_top):
  - CapIdle:
    - If cmd_data_i[15:12]==CmdOpConvolve, load pair_cnt=cmd_data_i[CountWidth-1:0] and param_cnt=ValArraySize-1, then go to CapParam.
    - Any other opcode is ignored.
  - CapParam:
    - Lasts exactly ValArraySize cycles. Decrement param_cnt each cycle; when param_cnt==0, go to CapExec with phase=0.
  - CapExec:
    - phase toggles every cycle.
    - phase=0: latch hi_q <= nn_data_i.
    - phase=1: push {hi_q, nn_data_i} into the FIFO. Then, if pair_cnt!=0, decrement pair_cnt; otherwise return to CapIdle.
  - Commands on cmd_data_i outside CapIdle are ignored.
- Timing:
  - Command seen at cycle T. Params occupy T+1..T+ValArraySize. Exec starts at T+ValArraySize+1 and spans 2*(count+1) cycles.
  - count=0 yields exactly one result.
- busy_o is high in CapParam and CapExec.
- Push latency: a result is visible on res_o/res_valid_o on the cycle after its low-byte cycle.
- FIFO rules:
  - Pop when res_valid_o & res_ready_i.
  - Push and pop in the same cycle are both honoured, including when full (occupancy unchanged, no overflow) and when empty is not involved (no bypass; an empty FIFO gives res_valid_o=0 that cycle).
  - Pointers wrap modulo FifoDepth.
- Overflow:
  - A push when full without a simultaneous pop drops the new result; FIFO contents are unchanged and overflow_o is set.
  - overflow_clr_i clears overflow_o. If a clear and a new overflow occur in the same cycle, set wins.
- res_o while FIFO is empty: holds its last value (don't-care for the consumer). It is 0 after reset.
- Reset mid-sequence: immediate return to CapIdle, FIFO flushed, any partial high byte discarded.

Decomposition:
- Reuse from tiny_nn_pkg: fp_t and CmdOpConvolve.
- Add to tiny_nn_pkg: a cap_state_e enum (CapIdle, CapParam, CapExec), so tiny_nn_top and this block share the encoding convention.
- One sub-module: tiny_nn_fifo, a generic synchronous FIFO parameterised on Width and Depth, with push/pop/full/empty. It is reusable for an input-side buffer later.

Test Plan:
- Convolve with count=0, nn_data_i=0x3C then 0x00 in the exec cycles -> exactly one result res_o=0x3C00, valid at T+11; busy_o deasserts after T+10.
- Convolve with count=2 and exec bytes 0x12,0x34,0x56,0x78,0x9A,0xBC, res_ready_i=1 -> results 0x1234, 0x5678, 0x9ABC in order, each popped the cycle it appears.
- FifoDepth=4, count=5, res_ready_i=0 -> 4 results held, results 5 and 6 dropped, overflow_o=1; then assert ready -> the first 4 are drained in order; overflow_clr_i -> overflow_o=0.
- FIFO full, and a pop in the same cycle as a push -> occupancy stays 4, overflow_o stays 0, order is preserved.
- A second convolve opcode injected during CapParam/CapExec -> ignored; result count matches the first command only.
- rst_ni pulsed low mid-CapExec after a high byte was latched -> res_valid_o=0 and busy_o=0 immediately; the next command behaves exactly like the first scenario.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// -----------------------------------------------------------------------------
// tiny_nn_pkg
// Types and constants shared by tiny_nn_top and the blocks around it.
//   fp_t          : 16-bit result word (high byte first on the 8-bit bus)
//   CmdOpConvolve : opcode in cmd_data_i[15:12] that starts a convolve sequence
//   cap_state_e   : sequencing states, same encoding convention as tiny_nn_top
// -----------------------------------------------------------------------------
package tiny_nn_pkg;

   typedef logic [15:0] fp_t;

   localparam logic [3:0] CmdOpConvolve = 4'h2;

   typedef enum logic [1:0] {
      CapIdle  = 2'd0,
      CapParam = 2'd1,
      CapExec  = 2'd2
   } cap_state_e;

endpackage

// File: rtl/tiny_nn_fifo.sv
// -----------------------------------------------------------------------------
// tiny_nn_fifo
// Generic synchronous FIFO, Depth must be a power of two (>=2).
// A pop is honoured only when non-empty; a push is honoured when not full, or
// when full together with a pop. No bypass: a push into an empty FIFO becomes
// visible on head_o the next cycle. While empty, head_o holds the last value
// popped (0 after reset).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i
//   push_data_i   : data to write
//   pop_i         : remove the head entry
//   head_o        : head entry (last popped value while empty)
//   full_o        : Depth entries held
//   empty_o       : no entries held
// -----------------------------------------------------------------------------
module tiny_nn_fifo #(
   parameter int Width = 16,
   parameter int Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AddrWidth:0] wr_ptr_q;
   logic [AddrWidth:0] rd_ptr_q;
   logic [Width-1:0]   mem_q [Depth];
   logic [Width-1:0]   last_q;
   logic               do_push;
   logic               do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                    (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q[AddrWidth-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q[AddrWidth-1:0]];
         end
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read once the
   // pointers say they were written, so a reset would only cost flops.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AddrWidth-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/tiny_nn_result_capture.sv
// -----------------------------------------------------------------------------
// tiny_nn_result_capture
// Snoops the command stream of tiny_nn_top, follows its convolve sequencing in
// lock-step, pairs the high/low bytes tiny_nn_top drives during execution into
// fp_t results and queues them for a valid/ready consumer.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   cmd_data_i      : copy of the word driven into tiny_nn_top data_i
//   nn_data_i       : tiny_nn_top data_o
//   res_o           : result at FIFO head
//   res_valid_o     : FIFO non-empty
//   res_ready_i     : consumer accepts res_o
//   busy_o          : capture sequence in progress
//   overflow_o      : sticky, a result was dropped on a full FIFO
//   overflow_clr_i  : clears overflow_o (a simultaneous new drop wins)
// -----------------------------------------------------------------------------
module tiny_nn_result_capture
   import tiny_nn_pkg::*;
#(
   parameter int CountWidth   = 12,
   parameter int ValArraySize = 8,
   parameter int FifoDepth    = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] cmd_data_i,
   input  logic [7:0]  nn_data_i,
   output logic [15:0] res_o,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic        busy_o,
   output logic        overflow_o,
   input  logic        overflow_clr_i
);

   localparam int ParamCntWidth = (ValArraySize > 1) ? $clog2(ValArraySize) : 1;

   cap_state_e               state_q, state_d;
   logic                     phase_q, phase_d;
   logic [CountWidth-1:0]    pair_cnt_q, pair_cnt_d;
   logic [ParamCntWidth-1:0] param_cnt_q, param_cnt_d;
   logic [7:0]               hi_q, hi_d;
   logic                     overflow_q, overflow_d;

   logic push;
   logic pop;
   logic fifo_full;
   logic fifo_empty;

   // NOTE: every signal written here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      pair_cnt_d  = pair_cnt_q;
      param_cnt_d = param_cnt_q;
      hi_d        = hi_q;
      push        = 1'b0;

      case (state_q)
         CapIdle: begin
            // Other opcodes are tiny_nn_top's business; only convolve produces output.
            if (cmd_data_i[15:12] == CmdOpConvolve) begin
               pair_cnt_d  = cmd_data_i[CountWidth-1:0];
               param_cnt_d = ParamCntWidth'(ValArraySize - 1);
               state_d     = CapParam;
            end
         end
         CapParam: begin
            if (param_cnt_q == '0) begin
               state_d = CapExec;
               phase_d = 1'b0;
            end else begin
               param_cnt_d = param_cnt_q - 1'b1;
            end
         end
         CapExec: begin
            phase_d = ~phase_q;
            if (!phase_q) begin
               hi_d = nn_data_i;
            end else begin
               push = 1'b1;
               if (pair_cnt_q != '0) pair_cnt_d = pair_cnt_q - 1'b1;
               else                  state_d    = CapIdle;
            end
         end
         default: state_d = CapIdle;
      endcase
   end

   assign pop = res_valid_o & res_ready_i;

   // A drop only happens when the FIFO cannot make room this same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (push && fifo_full && !pop) overflow_d = 1'b1;
      else if (overflow_clr_i)       overflow_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= CapIdle;
         phase_q     <= 1'b0;
         pair_cnt_q  <= '0;
         param_cnt_q <= '0;
         hi_q        <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         pair_cnt_q  <= pair_cnt_d;
         param_cnt_q <= param_cnt_d;
         hi_q        <= hi_d;
         overflow_q  <= overflow_d;
      end
   end

   tiny_nn_fifo #(
      .Width (16),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push),
      .push_data_i ({hi_q, nn_data_i}),
      .pop_i       (pop),
      .head_o      (res_o),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign res_valid_o = ~fifo_empty;
   assign busy_o      = (state_q != CapIdle);
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_tiny_nn_result_capture.sv
// -----------------------------------------------------------------------------
// tb_tiny_nn_result_capture
// Drives the capture block with directed and randomized convolve sequences and
// compares every output every cycle against a cycle-indexed queue model.
// -----------------------------------------------------------------------------
module tb_tiny_nn_result_capture;
   import tiny_nn_pkg::*;

   localparam int CountWidth   = 12;
   localparam int ValArraySize = 8;
   localparam int FifoDepth    = 4;

   logic        clk_i;
   logic        rst_ni;
   logic [15:0] cmd_data_i;
   logic [7:0]  nn_data_i;
   logic [15:0] res_o;
   logic        res_valid_o;
   logic        res_ready_i;
   logic        busy_o;
   logic        overflow_o;
   logic        overflow_clr_i;

   tiny_nn_result_capture #(
      .CountWidth   (CountWidth),
      .ValArraySize (ValArraySize),
      .FifoDepth    (FifoDepth)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cmd_data_i     (cmd_data_i),
      .nn_data_i      (nn_data_i),
      .res_o          (res_o),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .busy_o         (busy_o),
      .overflow_o     (overflow_o),
      .overflow_clr_i (overflow_clr_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Model: sequence window in absolute cycle numbers plus a queue for the FIFO.
   int   cyc        = 0;
   int   cmd_c      = -100;
   int   exec_start = -100;
   int   exec_end   = -100;
   fp_t  mq[$];
   fp_t  m_last     = '0;
   logic m_ovf      = 1'b0;
   logic [7:0] m_hi = '0;

   fp_t        seen[$];   // values the DUT handed over (valid & ready)
   logic [7:0] xb[$];     // exec-cycle bytes for the next run_conv

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cmd_c = -100; exec_start = -100; exec_end = -100;
      mq.delete(); m_last = '0; m_ovf = 1'b0; m_hi = '0;
   endtask

   // Advances the model across one rising edge with the inputs sampled there.
   task automatic model_update(input logic [15:0] cmd, input logic [7:0] nn,
                               input logic rdy, input logic clr);
      bit in_exec, lo, popped, drop;
      in_exec = (cyc >= exec_start) && (cyc <= exec_end);
      lo      = in_exec && (((cyc - exec_start) % 2) == 1);
      popped  = (mq.size() > 0) && rdy;
      drop    = 1'b0;
      if (popped) m_last = mq.pop_front();
      if (lo) begin
         if (mq.size() == FifoDepth) drop = 1'b1;
         else                        mq.push_back({m_hi, nn});
      end
      if (in_exec && !lo) m_hi = nn;
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (cyc > exec_end && cmd[15:12] == CmdOpConvolve) begin
         cmd_c      = cyc;
         exec_start = cyc + ValArraySize + 1;
         exec_end   = exec_start + 2 * (int'(cmd[CountWidth-1:0]) + 1) - 1;
      end
      cyc++;
   endtask

   task automatic compare();
      check("res_valid", res_valid_o, mq.size() > 0);
      check("busy", busy_o, (cyc > cmd_c) && (cyc <= exec_end));
      check("overflow", overflow_o, m_ovf);
      check("res", res_o, (mq.size() > 0) ? mq[0] : m_last);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic [15:0] cmd, input logic [7:0] nn,
                       input logic rdy, input logic clr);
      cmd_data_i = cmd; nn_data_i = nn; res_ready_i = rdy; overflow_clr_i = clr;
      if (res_valid_o && rdy) seen.push_back(res_o);
      @(posedge clk_i);
      model_update(cmd, nn, rdy, clr);
      @(negedge clk_i);
      compare();
   endtask

   function automatic logic [15:0] idle_cmd();
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == CmdOpConvolve) op = op + 4'd1;
      return {op, 12'($urandom)};
   endfunction

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(idle_cmd(), 8'($urandom), rdy, 1'b0);
   endtask

   // rmode: 0 never ready, 1 always ready, 2 ready on low-byte cycles, 3 random.
   task automatic run_conv(input int count, input int rmode, input bit inject);
      logic rdy;
      logic [15:0] cmd;
      step({CmdOpConvolve, 12'(count)}, 8'($urandom), rmode == 1, 1'b0);
      for (int i = 0; i < ValArraySize; i++) begin
         cmd = (inject && i == 3) ? {CmdOpConvolve, 12'd7} : 16'($urandom);
         rdy = (rmode == 1) || (rmode == 3 && $urandom_range(0, 1) == 1);
         step(cmd, 8'($urandom), rdy, 1'b0);
      end
      for (int j = 0; j < 2 * (count + 1); j++) begin
         cmd = (inject && j == 1) ? {CmdOpConvolve, 12'd3} : 16'($urandom);
         rdy = (rmode == 1) || (rmode == 2 && (j % 2) == 1) ||
               (rmode == 3 && $urandom_range(0, 1) == 1);
         step(cmd, (j < xb.size()) ? xb[j] : 8'($urandom), rdy, 1'b0);
      end
   endtask

   // Asserted mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset();
      #2 rst_ni = 1'b0;
      #1;
      check("rst_valid", res_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_overflow", overflow_o, 1'b0);
      check("rst_res", res_o, 16'h0000);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic check_seen(input string name, input fp_t exp[$]);
      check({name, "_n"}, seen.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < seen.size()) check(name, seen[i], exp[i]);
   endtask

   task automatic scenario_single();
      xb = '{8'h3C, 8'h00};
      run_conv(0, 0, 1'b0);
      check("s1_res", res_o, 16'h3C00);
      check("s1_valid", res_valid_o, 1'b1);
      check("s1_busy", busy_o, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);
   endtask

   initial begin
      rst_ni = 1'b0; cmd_data_i = '0; nn_data_i = '0;
      res_ready_i = 1'b0; overflow_clr_i = 1'b0;
      #1;
      check("init_valid", res_valid_o, 1'b0);
      check("init_busy", busy_o, 1'b0);
      check("init_overflow", overflow_o, 1'b0);
      check("init_res", res_o, 16'h0000);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(3, 1'b0);

      // count=0: one result, visible the cycle after its low byte.
      scenario_single();

      // count=2 with ready held: each result popped the cycle it appears.
      seen.delete();
      xb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      run_conv(2, 1, 1'b0);
      step(idle_cmd(), 8'h00, 1'b1, 1'b0);
      check_seen("s2_order", '{16'h1234, 16'h5678, 16'h9ABC});
      check("s2_valid", res_valid_o, 1'b0);
      check("s2_hold", res_o, 16'h9ABC);

      // count=5 into a depth-4 FIFO with no consumer: last two dropped.
      xb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
             8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
      run_conv(5, 0, 1'b0);
      check("s3_overflow", overflow_o, 1'b1);
      check("s3_head", res_o, 16'h1122);
      seen.delete();
      idle(5, 1'b1);
      check_seen("s3_drain", '{16'h1122, 16'h3344, 16'h5566, 16'h7788});
      check("s3_still_ovf", overflow_o, 1'b1);
      step(idle_cmd(), 8'h00, 1'b0, 1'b1);
      check("s3_clr", overflow_o, 1'b0);

      // Full FIFO, then every push coincides with a pop.
      xb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_conv(3, 0, 1'b0);
      check("s4_full_no_ovf", overflow_o, 1'b0);
      seen.delete();
      xb = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
      run_conv(1, 2, 1'b0);
      check("s4_ovf", overflow_o, 1'b0);
      check("s4_valid", res_valid_o, 1'b1);
      idle(5, 1'b1);
      check_seen("s4_order", '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'hA1A2, 16'hB1B2});

      // Convolve opcodes during param and exec phases are ignored.
      seen.delete();
      xb = '{8'hC0, 8'hDE, 8'hF0, 8'h0D};
      run_conv(1, 1, 1'b1);
      idle(20, 1'b1);
      check_seen("s5_ignore", '{16'hC0DE, 16'hF00D});
      check("s5_busy", busy_o, 1'b0);

      // Reset after a high byte has been latched, then a clean count=0 run.
      step({CmdOpConvolve, 12'd3}, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < ValArraySize; i++) step(16'($urandom), 8'h00, 1'b0, 1'b0);
      step(16'($urandom), 8'hAA, 1'b0, 1'b0);
      step(16'($urandom), 8'hBB, 1'b0, 1'b0);
      step(16'($urandom), 8'hCC, 1'b0, 1'b0);
      do_reset();
      idle(2, 1'b0);
      scenario_single();

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         int gap;
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++)
            step(idle_cmd(), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
         xb.delete();
         run_conv($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom));
      end
      idle(8, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
